// File: rtl/emergency_preempt.sv
// Conditions the raw emergency-vehicle sensor into a clean, held, rate-limited
// preemption request for the traffic-light controller, with an event counter.
module emergency_preempt #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int COOLDOWN_CYCLES = 32,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_in,
    input  logic             clear,
    output logic             emergency,
    output logic             busy,
    output logic [CNT_W-1:0] event_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HD_W = $clog2(HOLD_CYCLES + 1);
    localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, QUAL, ACTIVE, COOLDOWN} state_t;

    state_t            state_q, state_d;
    logic              s1_q, s2_q;
    logic [DB_W-1:0]   db_q, db_d;
    logic [HD_W-1:0]   hd_q, hd_d;
    logic [CD_W-1:0]   cd_q, cd_d;
    logic              emergency_q, emergency_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  event_count_q, event_count_d;

    // State, counters, synchronizer and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            db_q          <= '0;
            hd_q          <= '0;
            cd_q          <= '0;
            emergency_q   <= 1'b0;
            busy_q        <= 1'b0;
            event_count_q <= '0;
        end else begin
            state_q       <= state_d;
            s1_q          <= sensor_in;
            s2_q          <= s1_q;
            db_q          <= db_d;
            hd_q          <= hd_d;
            cd_q          <= cd_d;
            emergency_q   <= emergency_d;
            busy_q        <= busy_d;
            event_count_q <= event_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        hd_d    = hd_q;
        cd_d    = cd_q;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = QUAL;
                    db_d    = DB_W'(1);
                end
            end
            QUAL: begin
                if (clear || !s2_q) begin
                    state_d = IDLE;
                end else if (db_q == DB_MAX) begin
                    state_d = ACTIVE;
                    hd_d    = '0;
                end else begin
                    db_d = db_q + DB_W'(1);
                end
            end
            ACTIVE: begin
                // A manual cancel skips the remaining hold time.
                if (clear || (hd_q >= HD_LAST && !s2_q)) begin
                    state_d = COOLDOWN;
                    cd_d    = '0;
                end else if (hd_q < HD_LAST) begin
                    hd_d = hd_q + HD_W'(1);
                end
            end
            COOLDOWN: begin
                if (cd_q == CD_LAST) begin
                    state_d = IDLE;
                end else begin
                    cd_d = cd_q + CD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        emergency_d   = (state_d == ACTIVE);
        busy_d        = (state_d != IDLE);
        event_count_d = event_count_q;
        if (state_q == QUAL && state_d == ACTIVE && event_count_q != {CNT_W{1'b1}}) begin
            event_count_d = event_count_q + CNT_W'(1);
        end
    end

    assign emergency   = emergency_q;
    assign busy        = busy_q;
    assign event_count = event_count_q;

endmodule

// File: tb/tb_emergency_preempt.sv
// Directed-vector bench for emergency_preempt: default instance plus a
// narrow-counter instance for saturation.
module tb_emergency_preempt;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensor_in;
    logic       sensor_sat;
    logic       clear;
    logic       emergency, busy;
    logic [7:0] event_count;
    logic       emergency_sat, busy_sat;
    logic [1:0] event_count_sat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    emergency_preempt dut (
        .clk         (clk),
        .rst         (rst),
        .sensor_in   (sensor_in),
        .clear       (clear),
        .emergency   (emergency),
        .busy        (busy),
        .event_count (event_count)
    );

    emergency_preempt #(.CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .sensor_in   (sensor_sat),
        .clear       (1'b0),
        .emergency   (emergency_sat),
        .busy        (busy_sat),
        .event_count (event_count_sat)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic in_win(input int e, input int a1, input int b1,
                                    input int a2, input int b2, input int a3, input int b3);
        return (e >= a1 && e <= b1) || (e >= a2 && e <= b2) || (e >= a3 && e <= b3);
    endfunction

    // Edge 1 is the first edge after the call; sensor is high on edges inside
    // the windows, clear is high on clr_edge. bz_lo < 0 skips busy checks.
    task automatic run_case(input string tag, input int total,
                            input int a1, input int b1, input int a2, input int b2,
                            input int a3, input int b3, input int clr_edge,
                            input int em_lo, input int em_hi, input int bz_lo, input int bz_hi);
        sensor_in = in_win(1, a1, b1, a2, b2, a3, b3);
        clear     = (clr_edge == 1);
        for (int e = 1; e <= total; e++) begin
            @(posedge clk); #1;
            check_val($sformatf("%s_em@%0d", tag, e), 32'(emergency),
                      32'(e >= em_lo && e <= em_hi));
            if (bz_lo >= 0)
                check_val($sformatf("%s_busy@%0d", tag, e), 32'(busy),
                          32'(e >= bz_lo && e <= bz_hi));
            sensor_in = in_win(e + 1, a1, b1, a2, b2, a3, b3);
            clear     = (e + 1 == clr_edge);
        end
        sensor_in = 1'b0;
        clear     = 1'b0;
        $display("case %s done: event_count=%0d busy=%0d", tag, event_count, busy);
    endtask

    initial begin
        rst        = 1'b1;
        sensor_in  = 1'b0;
        sensor_sat = 1'b0;
        clear      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_em",   32'(emergency),   0);
        check_val("reset_busy", 32'(busy),        0);
        check_val("reset_cnt",  32'(event_count), 0);
        check_val("reset_sat",  32'(event_count_sat), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Clean 10-cycle request
        run_case("clean", 60, 1, 10, 0, 0, 0, 0, 0, 7, 22, 3, 54);
        check_val("clean_cnt", 32'(event_count), 1);

        // Three 3-cycle glitches never qualify
        run_case("glitch", 30, 1, 3, 6, 8, 11, 13, 0, 1, 0, -1, 0);
        check_val("glitch_busy", 32'(busy), 0);
        check_val("glitch_cnt", 32'(event_count), 1);

        // 60-cycle extension, then a pulse inside cooldown is ignored
        run_case("extend", 100, 1, 60, 71, 80, 0, 0, 0, 7, 62, 3, 94);
        check_val("extend_cnt", 32'(event_count), 2);

        // The same pulse after cooldown is accepted
        run_case("after_cd", 60, 1, 10, 0, 0, 0, 0, 0, 7, 22, 3, 54);
        check_val("after_cd_cnt", 32'(event_count), 3);

        // Clear sampled on the 5th ACTIVE cycle
        run_case("clr_act", 60, 1, 10, 0, 0, 0, 0, 12, 7, 11, 3, 43);
        check_val("clr_act_cnt", 32'(event_count), 4);

        // Pulse long enough to qualify, but clear during QUAL aborts it
        run_case("clr_qual", 20, 1, 5, 0, 0, 0, 0, 5, 1, 0, -1, 0);
        check_val("clr_qual_busy", 32'(busy), 0);
        check_val("clr_qual_cnt", 32'(event_count), 4);

        // Asynchronous reset in the middle of ACTIVE
        sensor_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_val("rst_pre_em", 32'(emergency), 1);
        #3 rst = 1'b1;
        #1;
        check_val("rst_async_em",   32'(emergency),   0);
        check_val("rst_async_busy", 32'(busy),        0);
        check_val("rst_async_cnt",  32'(event_count), 0);
        sensor_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_case("post_rst", 60, 1, 10, 0, 0, 0, 0, 0, 7, 22, 3, 54);
        check_val("post_rst_cnt", 32'(event_count), 1);

        // Saturation on a 2-bit counter
        for (int k = 1; k <= 5; k++) begin
            sensor_sat = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            sensor_sat = 1'b0;
            repeat (50) @(posedge clk);
            #1;
            check_val($sformatf("sat_cnt_req%0d", k), 32'(event_count_sat), (k < 3) ? k : 3);
            $display("sat request %0d: event_count=%0d", k, event_count_sat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/emergency_preempt.md
# emergency_preempt

Upstream conditioner for the `trafficlight` controller's `emergency` input. It takes the raw, asynchronous emergency-vehicle preemption sensor and synchronizes and debounces it. It converts the result into a clean registered `emergency` request with a guaranteed minimum hold time and a post-event cooldown lockout. It also keeps a saturating count of accepted preemption events for the maintenance interface.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized-high cycles needed to accept a request (≥1).
- `HOLD_CYCLES`, default 16: minimum cycles `emergency` stays high once asserted (≥1).
- `COOLDOWN_CYCLES`, default 32: cycles the sensor is ignored after a request ends (≥1).
- `CNT_W`, default 8: width of `event_count`.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `sensor_in`  input  1  raw preemption sensor; asynchronous and may glitch.
- `clear`  input  1  synchronous manual cancel from the operator panel.
- `emergency`  output  1  registered request to `trafficlight.emergency`.
- `busy`  output  1  registered; high whenever the FSM is not in IDLE.
- `event_count`  output  CNT_W  registered; saturating count of accepted requests.

## Operation
- Synchronizer: two flops, `s1 <= sensor_in` and `s2 <= s1`. The FSM uses only `s2`.
- States: IDLE, QUAL, ACTIVE, COOLDOWN. Separate counters hold the debounce, hold and cooldown counts.
- Transitions from IDLE:
  - `s2`=1 → QUAL, debounce count = 1.
- Transitions from QUAL:
  - `s2`=0 → IDLE, with no event counted.
  - `s2`=1 and count < DEBOUNCE_CYCLES → count+1.
  - `s2`=1 and count == DEBOUNCE_CYCLES → ACTIVE. The hold counter clears and `event_count` increments, saturating at 2^CNT_W−1.
- Transitions from ACTIVE:
  - Hold counter increments each cycle.
  - Exit to COOLDOWN when hold count ≥ HOLD_CYCLES−1 and `s2`=0.
  - While `s2` stays high, ACTIVE extends indefinitely.
- Transitions from COOLDOWN:
  - `s2` is ignored.
  - After exactly COOLDOWN_CYCLES cycles → IDLE.
  - If `s2` is still high on return, the next edge enters QUAL, which starts a fresh qualification.
- `clear` has highest priority:
  - In QUAL → IDLE.
  - In ACTIVE → COOLDOWN, even if the hold time is unmet.
  - In IDLE or COOLDOWN: no effect.
- Outputs: `emergency` = (next state == ACTIVE), registered. `busy` = (next state != IDLE), registered.
- Counter widths are sized to their parameter maximum. Counters never wrap inside a state.

## Timing
- Reset (async assert): state IDLE, `s1`=`s2`=0, all counters 0, `emergency`=0, `busy`=0, `event_count`=0. Deassert is synchronized externally; the block only needs correct behaviour from the first edge after release.
- Assertion latency: number the first edge that samples `sensor_in` high as edge 1.
  - `emergency` rises after edge DEBOUNCE_CYCLES+3 (edge 7 with defaults).
  - `busy` rises after edge 3.
- A sensor pulse shorter than DEBOUNCE_CYCLES+1 synchronized cycles never asserts `emergency`.
- Hold: `emergency` is high exactly HOLD_CYCLES cycles if `s2` is already low. Otherwise it falls on the first edge after hold expiry at which `s2`=0.
- Cooldown: `emergency` is low and `busy` is high for exactly COOLDOWN_CYCLES cycles. `busy` falls on the following edge.
- Reset mid-ACTIVE: `emergency` drops immediately (asynchronously) and `event_count` clears.

## Test plan
- Clean request: `sensor_in` high for 10 cycles (defaults) → `emergency` high from after edge 7 for 16 cycles, then `busy` high for 32 more cycles; `event_count`=1.
- Glitch rejection: three 3-cycle pulses on `sensor_in` separated by 2 low cycles → `emergency` never asserts, `event_count`=0, `busy` returns to 0.
- Extension and lockout: `sensor_in` high for 60 cycles → `emergency` high until 2–3 cycles after `sensor_in` falls. A new 10-cycle pulse inside the 32-cycle cooldown is ignored (`event_count` stays 1). The same pulse after cooldown is accepted (`event_count`=2).
- Clear: `clear` pulsed for 1 cycle on the 5th cycle of ACTIVE → `emergency` low next edge, then 32 cooldown cycles. `clear` during QUAL → IDLE, no count.
- Async reset: assert `rst` mid-ACTIVE between clock edges → `emergency`, `busy` and `event_count` go to 0 before the next edge. The next request qualifies normally.
- Saturation: with CNT_W=2, five accepted requests → `event_count` reads 3 after the 3rd, 4th and 5th requests.
